camera_sensor_emulator: RTL and testbench

Synthesizable model of the camera side of the parallel pixel bus: on a trigger it produces an exposure strobe and one frame of 12-bit test-pattern pixels with a pixel clock, frame-valid and line-valid, exactly as a physical camera presents them. It sits in place of Camera 0 or Camera 1 in self-test builds and simulation, driven by the camera interface's trigger output and feeding its `pixel_data_x`, `pixel_clk_x`, `FV_x`, `LV_x` and `Strobe_x` inputs.

---
 rtl/camera_sensor_emulator_if.sv | 21 ++
 rtl/camera_sensor_emulator.sv | 168 ++++++++++++++++
 tb/tb_camera_sensor_emulator.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/camera_sensor_emulator_if.sv
// camera_sensor_emulator_if: parallel pixel bus between an emulated camera and its receiver
interface camera_sensor_emulator_if;
  logic        trigger;
  logic [1:0]  pattern;
  logic [11:0] pixel_data;
  logic        pixel_clk;
  logic        FV;
  logic        LV;
  logic        Strobe;
  logic        busy;
  logic        trigger_dropped;
  logic [15:0] frame_count;
  modport master (
    input  trigger, pattern,
    output pixel_data, pixel_clk, FV, LV, Strobe, busy, trigger_dropped, frame_count
  );
  modport slave (
    output trigger, pattern,
    input  pixel_data, pixel_clk, FV, LV, Strobe, busy, trigger_dropped, frame_count
  );
endinterface

// File: rtl/camera_sensor_emulator.sv
// camera_sensor_emulator: triggered test-pattern camera producing Strobe, FV, LV and 12-bit pixels
module camera_sensor_emulator #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int HBLANK      = 16,
  parameter int FV_LEAD     = 2,
  parameter int VBLANK      = 4,
  parameter int EXPOSURE    = 8,
  parameter int PIXEL_DIV   = 2
) (
  input logic sysClk,
  input logic hard_reset_n,
  camera_sensor_emulator_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_FRONT, S_LINE, S_HBLANK, S_BACK, S_VBLANK} state_t;
  localparam int MAXA = (EXPOSURE > FV_LEAD) ? EXPOSURE : FV_LEAD;
  localparam int MAXB = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int TW = $clog2(((MAXA > MAXB) ? MAXA : MAXB) + 1);
  localparam int CW = $clog2(ACTIVE_COLS);
  localparam int RW = $clog2(ACTIVE_ROWS + 1);
  localparam int DW = $clog2(PIXEL_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(PIXEL_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(PIXEL_DIV / 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(ACTIVE_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ACTIVE_ROWS - 1);
  localparam logic [TW-1:0] EXP_LAST  = TW'(EXPOSURE - 1);
  localparam logic [TW-1:0] LEAD_LAST = TW'(FV_LEAD - 1);
  localparam logic [TW-1:0] HB_LAST   = TW'(HBLANK - 1);
  localparam logic [TW-1:0] VB_LAST   = TW'(VBLANK - 1);
  state_t r_state, w_state;
  logic [DW-1:0] r_div, w_div;
  logic [TW-1:0] r_cnt, w_cnt;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [11:0] r_pcnt, w_pcnt;
  logic [1:0] r_pat, w_pat;
  logic [15:0] r_fcnt, w_fcnt;
  logic r_pclk, r_trig_q, r_drop;
  logic r_busy, w_busy, r_pend, w_pend, r_fv, w_fv, r_lv, w_lv, r_strobe, w_strobe;
  logic w_tick, w_edge;
  logic [11:0] w_pix;
  assign w_tick = (r_div == DIV_LAST);
  assign w_div  = w_tick ? '0 : r_div + DW'(1);
  assign w_edge = bus.trigger & ~r_trig_q;
  assign w_pix  = (r_pat == 2'd0) ? 12'(r_col) :
                  (r_pat == 2'd1) ? 12'(r_row) :
                  (r_pat == 2'd2) ? {12{r_col[0] ^ r_row[0]}} : r_pcnt;
  assign bus.pixel_data      = r_lv ? w_pix : '0;
  assign bus.pixel_clk       = r_pclk;
  assign bus.FV              = r_fv;
  assign bus.LV              = r_lv;
  assign bus.Strobe          = r_strobe;
  assign bus.busy            = r_busy;
  assign bus.trigger_dropped = r_drop;
  assign bus.frame_count     = r_fcnt;
  // Every sequence step advances only on a pixel tick, so outputs move on pixel_clk falling edges
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_col    = r_col;
    w_row    = r_row;
    w_pcnt   = r_pcnt;
    w_pat    = r_pat;
    w_fcnt   = r_fcnt;
    w_busy   = r_busy;
    w_pend   = r_pend;
    w_fv     = r_fv;
    w_lv     = r_lv;
    w_strobe = r_strobe;
    case (r_state)
      S_IDLE: if (w_edge) begin
        w_state = S_EXPOSE;
        w_pat   = bus.pattern;
        w_busy  = 1'b1;
        w_pend  = 1'b1;
      end
      S_EXPOSE: if (w_tick) begin
        if (r_pend) begin
          w_pend   = 1'b0;
          w_strobe = 1'b1;
          w_cnt    = '0;
        end else if (r_cnt == EXP_LAST) begin
          w_strobe = 1'b0;
          w_fv     = 1'b1;
          w_pcnt   = '0;
          w_row    = '0;
          w_cnt    = '0;
          w_state  = S_FRONT;
        end else w_cnt = r_cnt + TW'(1);
      end
      S_FRONT: if (w_tick) begin
        if (r_cnt == LEAD_LAST) begin
          w_lv    = 1'b1;
          w_col   = '0;
          w_state = S_LINE;
        end else w_cnt = r_cnt + TW'(1);
      end
      S_LINE: if (w_tick) begin
        w_pcnt = r_pcnt + 12'd1;
        if (r_col == COL_LAST) begin
          w_lv    = 1'b0;
          w_cnt   = '0;
          w_state = (r_row == ROW_LAST) ? S_BACK : S_HBLANK;
        end else w_col = r_col + CW'(1);
      end
      S_HBLANK: if (w_tick) begin
        if (r_cnt == HB_LAST) begin
          w_row   = r_row + RW'(1);
          w_col   = '0;
          w_lv    = 1'b1;
          w_state = S_LINE;
        end else w_cnt = r_cnt + TW'(1);
      end
      S_BACK: if (w_tick) begin
        if (r_cnt == LEAD_LAST) begin
          w_fv    = 1'b0;
          w_cnt   = '0;
          w_state = S_VBLANK;
        end else w_cnt = r_cnt + TW'(1);
      end
      S_VBLANK: if (w_tick) begin
        if (r_cnt == VB_LAST) begin
          w_fcnt  = r_fcnt + 16'd1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else w_cnt = r_cnt + TW'(1);
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge sysClk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_pcnt   <= '0;
      r_pat    <= '0;
      r_fcnt   <= '0;
      r_pclk   <= 1'b0;
      r_trig_q <= 1'b0;
      r_drop   <= 1'b0;
      r_busy   <= 1'b0;
      r_pend   <= 1'b0;
      r_fv     <= 1'b0;
      r_lv     <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_div    <= w_div;
      r_cnt    <= w_cnt;
      r_col    <= w_col;
      r_row    <= w_row;
      r_pcnt   <= w_pcnt;
      r_pat    <= w_pat;
      r_fcnt   <= w_fcnt;
      r_pclk   <= (w_div >= DIV_HALF);
      r_trig_q <= bus.trigger;
      r_drop   <= w_edge & r_busy;
      r_busy   <= w_busy;
      r_pend   <= w_pend;
      r_fv     <= w_fv;
      r_lv     <= w_lv;
      r_strobe <= w_strobe;
    end
  end
endmodule

// File: tb/tb_camera_sensor_emulator.sv
// tb_camera_sensor_emulator: scoreboard bench with a frame-level pixel model for two camera geometries
module tb_camera_sensor_emulator;
  localparam int COLS = 4, ROWS = 3, HB = 2, LEAD = 2, VB = 3, EXPO = 5, DIV = 2;
  localparam int BCOLS = 64, BROWS = 70;
  logic sysClk = 1'b0;
  logic hard_reset_n = 1'b1;
  int checks = 0, errors = 0, drops_a = 0, exp_fc = 0, idx_b = 0;
  logic [11:0] qa[$], qb[$];
  camera_sensor_emulator_if bus_a();
  camera_sensor_emulator_if bus_b();
  camera_sensor_emulator #(.ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS), .HBLANK(HB), .FV_LEAD(LEAD),
    .VBLANK(VB), .EXPOSURE(EXPO), .PIXEL_DIV(DIV))
    dut_a (.sysClk(sysClk), .hard_reset_n(hard_reset_n), .bus(bus_a));
  camera_sensor_emulator #(.ACTIVE_COLS(BCOLS), .ACTIVE_ROWS(BROWS), .HBLANK(HB), .FV_LEAD(LEAD),
    .VBLANK(VB), .EXPOSURE(EXPO), .PIXEL_DIV(DIV))
    dut_b (.sysClk(sysClk), .hard_reset_n(hard_reset_n), .bus(bus_b));
  always #5 sysClk = ~sysClk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [11:0] model(input int pat, input int r, input int c, input int idx);
    case (pat)
      0: return 12'(c);
      1: return 12'(r);
      2: return ((c + r) % 2 == 1) ? 12'hFFF : 12'h000;
      default: return 12'(idx % 4096);
    endcase
  endfunction
  task automatic push_frame(input bit b, input int pat);
    int cols = b ? BCOLS : COLS;
    int rows = b ? BROWS : ROWS;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (b) qb.push_back(model(pat, r, c, r * cols + c));
        else qa.push_back(model(pat, r, c, r * cols + c));
  endtask
  task automatic check_zero(input string t);
    check({t, "_pclk"}, bus_a.pixel_clk, 0);
    check({t, "_fv"}, bus_a.FV, 0);
    check({t, "_lv"}, bus_a.LV, 0);
    check({t, "_strobe"}, bus_a.Strobe, 0);
    check({t, "_busy"}, bus_a.busy, 0);
    check({t, "_drop"}, bus_a.trigger_dropped, 0);
    check({t, "_data"}, bus_a.pixel_data, 0);
    check({t, "_fcount"}, bus_a.frame_count, 0);
  endtask
  task automatic fire_a(input int pat);
    @(negedge sysClk);
    bus_a.pattern = 2'(pat);
    bus_a.trigger = 1'b1;
    push_frame(1'b0, pat);
    @(negedge sysClk);
    check("busy_rise", bus_a.busy, 1);
    bus_a.pattern = 2'($urandom);
  endtask
  task automatic wait_idle_a();
    int n = 0;
    while (bus_a.busy && n < 2000) begin @(negedge sysClk); n++; end
    if (bus_a.busy) begin
      checks++; errors++;
      $display("FAIL timeout_idle_a: busy=1 required 0 after %0d cycles", n);
    end
  endtask
  task automatic wait_fv_fall_a();
    int n = 0;
    while (!bus_a.FV && n < 2000) begin @(negedge sysClk); n++; end
    while (bus_a.FV && n < 2000) begin @(negedge sysClk); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL timeout_fv_a: FV=%0d, no FV pulse within %0d cycles", bus_a.FV, n);
    end
  endtask
  logic pa_prev = 1'b0, fa_prev = 1'b0, la_prev = 1'b0, sa_prev = 1'b0;
  int fv_ticks = 0, lv_len = 0, lv_pulses = 0, st_len = 0;
  always @(negedge sysClk) begin
    if (!hard_reset_n) begin
      pa_prev = 1'b0; fa_prev = 1'b0; la_prev = 1'b0; sa_prev = 1'b0;
      fv_ticks = 0; lv_len = 0; lv_pulses = 0; st_len = 0;
    end else begin
      if (bus_a.trigger_dropped) drops_a++;
      if (bus_a.Strobe) st_len++;
      else if (sa_prev) begin check("strobe_len", st_len, EXPO * DIV); st_len = 0; end
      sa_prev = bus_a.Strobe;
      if (bus_a.pixel_clk && !pa_prev) begin
        if (bus_a.FV) fv_ticks++;
        else if (fa_prev) begin
          check("fv_ticks", fv_ticks, 2 * LEAD + ROWS * COLS + (ROWS - 1) * HB);
          check("lv_pulses", lv_pulses, ROWS);
          fv_ticks = 0; lv_pulses = 0;
        end
        fa_prev = bus_a.FV;
        if (bus_a.LV) begin
          lv_len++;
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL pix_a_extra: got pixel %0d, no pixel expected", bus_a.pixel_data);
          end else check("pix_a", bus_a.pixel_data, qa.pop_front());
        end else begin
          if (la_prev) begin check("lv_len", lv_len, COLS); lv_pulses++; end
          lv_len = 0;
          check("pix_a_blank", bus_a.pixel_data, 0);
        end
        la_prev = bus_a.LV;
      end
      pa_prev = bus_a.pixel_clk;
    end
  end
  logic pb_prev = 1'b0;
  always @(negedge sysClk) begin
    if (!hard_reset_n) begin
      pb_prev = 1'b0; idx_b = 0;
    end else begin
      if (bus_b.pixel_clk && !pb_prev && bus_b.LV) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_b_extra: got pixel %0d, no pixel expected", bus_b.pixel_data);
        end else check("pix_b", bus_b.pixel_data, qb.pop_front());
        if (idx_b == 4095) check("pix_b_4095", bus_b.pixel_data, 12'hFFF);
        if (idx_b == 4096) check("pix_b_4096", bus_b.pixel_data, 12'h000);
        if (idx_b == BCOLS * BROWS - 1) check("pix_b_last", bus_b.pixel_data, 12'h17F);
        idx_b++;
      end
      pb_prev = bus_b.pixel_clk;
    end
  end
  initial begin
    logic p0, p1, p2;
    int n;
    bus_a.trigger = 1'b0; bus_a.pattern = 2'd0;
    bus_b.trigger = 1'b0; bus_b.pattern = 2'd0;
    #1 hard_reset_n = 1'b0;
    #1 check_zero("rst_init");
    repeat (3) @(negedge sysClk);
    hard_reset_n = 1'b1;
    @(negedge sysClk); p0 = bus_a.pixel_clk;
    @(negedge sysClk); p1 = bus_a.pixel_clk;
    @(negedge sysClk); p2 = bus_a.pixel_clk;
    check("pclk_half", p1, !p0);
    check("pclk_period", p2, p0);
    fire_a(0);
    wait_idle_a();
    exp_fc++;
    repeat (20) @(negedge sysClk);
    check("held_trigger_one_frame", bus_a.busy, 0);
    check("fcount_1", bus_a.frame_count, exp_fc);
    check("queue_a_empty_1", qa.size(), 0);
    bus_a.trigger = 1'b0;
    fire_a(1);
    @(negedge sysClk); bus_a.trigger = 1'b0;
    repeat (7) @(negedge sysClk); bus_a.trigger = 1'b1;
    @(negedge sysClk); bus_a.trigger = 1'b0;
    repeat (9) @(negedge sysClk); bus_a.trigger = 1'b1;
    @(negedge sysClk); bus_a.trigger = 1'b0;
    wait_fv_fall_a();
    repeat (VB * DIV - 1) @(negedge sysClk);
    bus_a.trigger = 1'b1;
    @(negedge sysClk); #1;
    exp_fc++;
    check("busy_fell", bus_a.busy, 0);
    check("drops_busy", drops_a, 3);
    check("fcount_2", bus_a.frame_count, exp_fc);
    bus_a.trigger = 1'b0;
    fire_a(2);
    @(negedge sysClk); bus_a.trigger = 1'b0;
    wait_fv_fall_a();
    repeat (VB * DIV) @(negedge sysClk);
    exp_fc++;
    check("busy_low_before_accept", bus_a.busy, 0);
    bus_a.pattern = 2'd3;
    bus_a.trigger = 1'b1;
    push_frame(1'b0, 3);
    @(negedge sysClk);
    check("accept_after_fall", bus_a.busy, 1);
    bus_a.trigger = 1'b0;
    wait_idle_a();
    exp_fc++;
    #1;
    check("drops_after_accept", drops_a, 3);
    check("fcount_4", bus_a.frame_count, exp_fc);
    for (int k = 0; k < 4; k++) begin
      fire_a(int'($urandom_range(0, 3)));
      repeat ($urandom_range(1, 30)) @(negedge sysClk);
      bus_a.trigger = 1'b0;
      wait_idle_a();
      exp_fc++;
      check("fcount_rand", bus_a.frame_count, exp_fc);
    end
    check("queue_a_empty_rand", qa.size(), 0);
    fire_a(int'($urandom_range(0, 3)));
    n = 0;
    while (!bus_a.LV && n < 2000) begin @(negedge sysClk); n++; end
    check("lv_seen_before_reset", bus_a.LV, 1);
    repeat (3) @(posedge sysClk);
    #3 hard_reset_n = 1'b0;
    #1 check_zero("rst_mid");
    qa.delete();
    bus_a.trigger = 1'b0;
    repeat (3) @(negedge sysClk);
    hard_reset_n = 1'b1;
    @(negedge sysClk);
    check("fcount_after_reset", bus_a.frame_count, 0);
    fire_a(int'($urandom_range(0, 3)));
    bus_a.trigger = 1'b0;
    wait_idle_a();
    check("fcount_restart", bus_a.frame_count, 1);
    check("queue_a_empty_restart", qa.size(), 0);
    @(negedge sysClk);
    bus_b.pattern = 2'd3;
    bus_b.trigger = 1'b1;
    push_frame(1'b1, 3);
    @(negedge sysClk);
    check("busy_b_rise", bus_b.busy, 1);
    bus_b.trigger = 1'b0;
    n = 0;
    while (bus_b.busy && n < 20000) begin @(negedge sysClk); n++; end
    check("busy_b_done", bus_b.busy, 0);
    check("fcount_b", bus_b.frame_count, 1);
    check("pixels_b", idx_b, BCOLS * BROWS);
    check("queue_b_empty", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
